// File: rtl/music_recorder.sv
// rtl/music_recorder.sv - records live keyboard tones into score RAM as (tone, length) entries plus end marker
// Optional input debounce filter: define MUSIC_RECORDER_DEBOUNCE_EN.
module music_recorder #(
    parameter int ADDR_W         = 10,
    parameter int DEPTH          = 1024,
    parameter int TICKS_PER_UNIT = 3125000,
    parameter int DEBOUNCE_CYC   = 250000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [6:0]        Tone,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [6:0]        RamTone,
    output logic [6:0]        RamNote,
    output logic              RamWE,
    output logic              Recording,
    output logic              Full
);
    localparam int PW = $clog2(TICKS_PER_UNIT + 1);

    typedef enum logic [2:0] {IDLE, RUN, FLUSH, TERM, DONE} state_t;

    state_t            state, state_n;
    logic [6:0]        sync1, sync2, tone_f;
    logic [6:0]        cur_tone, cur_n, dur, dur_n, wr_tone, wr_note;
    logic [PW-1:0]     presc, presc_n;
    logic [ADDR_W-1:0] addr_n;
    logic              full_n, wr, tick;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= Tone;
            sync2 <= sync1;
        end
    end

`ifdef MUSIC_RECORDER_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    logic [6:0]    cand;
    logic [DW-1:0] stable_cnt;

    // A candidate value must survive DEBOUNCE_CYC samples before it replaces tone_f.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cand       <= '0;
            stable_cnt <= '0;
            tone_f     <= '0;
        end else if (sync2 != cand) begin
            cand       <= sync2;
            stable_cnt <= '0;
        end else if (stable_cnt == DW'(DEBOUNCE_CYC - 1)) begin
            tone_f <= cand;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end
`else
    assign tone_f = sync2;
`endif

    assign tick      = (presc == PW'(TICKS_PER_UNIT - 1));
    assign Recording = (state == RUN) || (state == FLUSH) || (state == TERM);

    always_comb begin
        state_n = state;
        cur_n   = cur_tone;
        dur_n   = dur;
        presc_n = presc;
        full_n  = Full;
        wr      = 1'b0;
        wr_tone = cur_tone;
        wr_note = dur;
        // The address advances after each strobe except the end marker, which stays visible in DONE.
        addr_n  = (RamWE && state != DONE) ? RamAddr + 1'b1 : RamAddr;
        case (state)
            IDLE: begin
                if (EN) begin
                    state_n = RUN;
                    addr_n  = '0;
                    full_n  = 1'b0;
                    cur_n   = tone_f;
                    dur_n   = '0;
                    presc_n = '0;
                end
            end
            RUN: begin
                if (!EN) begin
                    state_n = FLUSH;
                end else begin
                    presc_n = tick ? '0 : presc + 1'b1;
                    if (tone_f != cur_tone) begin
                        wr      = (dur != 7'd0);
                        cur_n   = tone_f;
                        dur_n   = '0;
                        presc_n = '0;
                    end else if (tick) begin
                        if (dur == 7'd126) begin
                            wr      = 1'b1;
                            wr_note = 7'd127;
                            dur_n   = '0;
                        end else begin
                            dur_n = dur + 7'd1;
                        end
                    end
                    if (wr && addr_n == ADDR_W'(DEPTH - 2)) begin
                        full_n  = 1'b1;
                        state_n = TERM;
                    end
                end
            end
            FLUSH: begin
                wr      = (dur != 7'd0);
                state_n = TERM;
            end
            TERM: begin
                wr      = 1'b1;
                wr_tone = '0;
                wr_note = '0;
                state_n = DONE;
            end
            DONE: begin
                if (!EN) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cur_tone <= '0;
            dur      <= '0;
            presc    <= '0;
            Full     <= 1'b0;
            RamAddr  <= '0;
            RamTone  <= '0;
            RamNote  <= '0;
            RamWE    <= 1'b0;
        end else begin
            state    <= state_n;
            cur_tone <= cur_n;
            dur      <= dur_n;
            presc    <= presc_n;
            Full     <= full_n;
            RamAddr  <= addr_n;
            RamWE    <= wr;
            if (wr) begin
                RamTone <= wr_tone;
                RamNote <= wr_note;
            end
        end
    end
endmodule
